// File: rtl/noncon_rep_checker.sv
// noncon_rep_checker: per-channel req/busy/gnt repetition checker with saturating pass/fail statistics
//
// Each channel requires exactly BUSY_COUNT busy cycles (not necessarily
// consecutive) between req and gnt. MODE 0 accepts gnt any time after the
// last busy, MODE 1 requires gnt on the cycle right after it.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   en         channel enable; low forces every channel to IDLE silently
//   clr_cnt    synchronous clear of pass_cnt/fail_cnt, beats increments
//   req        per-channel request
//   busy       per-channel busy
//   gnt        per-channel grant
//   active     channel is tracking a transaction
//   pass       one-cycle pulse on a correct transaction
//   fail       one-cycle pulse on a failed transaction
//   fail_code  3 bits per channel, updated with fail, held otherwise
//              1 EARLY_GNT, 2 EXTRA_BUSY, 3 MISSED_GNT, 4 TIMEOUT, 5 OVERLAP
//   pass_cnt   saturating count of pass pulses over all channels
//   fail_cnt   saturating count of fail pulses over all channels
module noncon_rep_checker #(
    parameter int NUM_CH     = 4,
    parameter int BUSY_COUNT = 3,
    parameter int MODE       = 0,
    parameter int MAX_WAIT   = 64,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr_cnt,
    input  logic [NUM_CH-1:0]     req,
    input  logic [NUM_CH-1:0]     busy,
    input  logic [NUM_CH-1:0]     gnt,
    output logic [NUM_CH-1:0]     active,
    output logic [NUM_CH-1:0]     pass,
    output logic [NUM_CH-1:0]     fail,
    output logic [3*NUM_CH-1:0]   fail_code,
    output logic [STAT_W-1:0]     pass_cnt,
    output logic [STAT_W-1:0]     fail_cnt
);
    localparam int BW = $clog2(BUSY_COUNT + 1);
    localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
    // headroom so counter + popcount never wraps before the saturation test
    localparam int CW = STAT_W + $clog2(NUM_CH + 1) + 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t        st;
        logic [BW-1:0] bc;
        logic [WW-1:0] wc;
        logic          p, f, ok, early, extra, missed, tout, bad, ovl;
        logic [2:0]    fc, code;

        // gnt is judged against bc before this cycle's busy is counted
        always_comb begin
            ok     = st == DONE && gnt[c];
            early  = st == COUNT && gnt[c];
            extra  = st == DONE && busy[c] && !gnt[c];
            // in goto mode any DONE cycle without gnt is necessarily the first one
            missed = MODE == 1 && st == DONE && !gnt[c];
            tout   = st != IDLE && MAX_WAIT > 0 && int'(wc) + 1 == MAX_WAIT;
            bad    = !ok && (early || extra || missed || tout);
            ovl    = st != IDLE && req[c] && !ok && !bad;
            code   = early ? 3'd1 : extra ? 3'd2 : missed ? 3'd3 : 3'd4;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st <= IDLE;
                bc <= '0;
                wc <= '0;
                p  <= 1'b0;
                f  <= 1'b0;
                fc <= '0;
            end else begin
                p <= 1'b0;
                f <= 1'b0;
                if (!en) begin
                    st <= IDLE;
                end else if (ok || bad) begin
                    // a req in the deciding cycle starts the next transaction back-to-back
                    p  <= ok;
                    f  <= bad;
                    if (bad)
                        fc <= code;
                    st <= req[c] ? COUNT : IDLE;
                    bc <= '0;
                    wc <= '0;
                end else if (req[c]) begin
                    // fresh start from IDLE, or OVERLAP restart while tracking
                    f  <= ovl;
                    if (ovl)
                        fc <= 3'd5;
                    st <= COUNT;
                    bc <= '0;
                    wc <= '0;
                end else if (st != IDLE) begin
                    wc <= wc + WW'(1);
                    if (st == COUNT && busy[c]) begin
                        bc <= bc + BW'(1);
                        if (int'(bc) + 1 == BUSY_COUNT)
                            st <= DONE;
                    end
                end
            end
        end

        assign active[c]          = st != IDLE;
        assign pass[c]            = p;
        assign fail[c]            = f;
        assign fail_code[3*c +: 3] = fc;
    end

    logic [CW-1:0] pass_sum, fail_sum;

    // counters accumulate the registered pulses, so they trail them by one edge
    always_comb begin
        pass_sum = CW'(pass_cnt) + CW'($countones(pass));
        fail_sum = CW'(fail_cnt) + CW'($countones(fail));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (clr_cnt) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            pass_cnt <= |pass_sum[CW-1:STAT_W] ? '1 : pass_sum[STAT_W-1:0];
            fail_cnt <= |fail_sum[CW-1:STAT_W] ? '1 : fail_sum[STAT_W-1:0];
        end
    end
endmodule

// File: tb/tb_noncon_rep_checker.sv
// tb_noncon_rep_checker: randomized bench for noncon_rep_checker against a transaction-level model
module tb_noncon_rep_checker;
    localparam int N  = 3;
    localparam int NC = 4;
    localparam int MW = 10;

    logic clk = 1'b0;
    logic rst, en, clr;
    logic [NC-1:0]   rq [2];
    logic [NC-1:0]   bs [2];
    logic [NC-1:0]   gn [2];
    logic [NC-1:0]   act [2];
    logic [NC-1:0]   ps [2];
    logic [NC-1:0]   fl [2];
    logic [3*NC-1:0] fcd [2];
    logic [15:0]     pc0, fc0;
    logic [1:0]      pc1, fc1;

    always #5 clk = ~clk;

    noncon_rep_checker #(.NUM_CH(NC), .BUSY_COUNT(N), .MODE(0), .MAX_WAIT(MW), .STAT_W(16)) dut0 (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr),
        .req(rq[0]), .busy(bs[0]), .gnt(gn[0]),
        .active(act[0]), .pass(ps[0]), .fail(fl[0]), .fail_code(fcd[0]),
        .pass_cnt(pc0), .fail_cnt(fc0)
    );

    noncon_rep_checker #(.NUM_CH(NC), .BUSY_COUNT(N), .MODE(1), .MAX_WAIT(MW), .STAT_W(2)) dut1 (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr),
        .req(rq[1]), .busy(bs[1]), .gnt(gn[1]),
        .active(act[1]), .pass(ps[1]), .fail(fl[1]), .fail_code(fcd[1]),
        .pass_cnt(pc1), .fail_cnt(fc1)
    );

    // model: per channel, whether a transaction is open, busies seen and cycles elapsed
    int trk [2][NC];
    int nb  [2][NC];
    int age [2][NC];
    int ec  [2][NC];
    int ep  [2][NC];
    int ef  [2][NC];
    int mpc [2];
    int mfc [2];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mpc[i] = 0;
            mfc[i] = 0;
            for (int c = 0; c < NC; c++) begin
                trk[i][c] = 0; nb[i][c] = 0; age[i][c] = 0;
                ec[i][c] = 0; ep[i][c] = 0; ef[i][c] = 0;
            end
        end
    endtask

    // one clock edge of instance i given the inputs currently driven
    task automatic step(input int i, input int mode, input int smax);
        int np, nf, code, ok, r, b, g;
        np = 0;
        nf = 0;
        for (int c = 0; c < NC; c++) begin
            np += ep[i][c];
            nf += ef[i][c];
        end
        if (clr) begin
            mpc[i] = 0;
            mfc[i] = 0;
        end else begin
            mpc[i] = mpc[i] + np > smax ? smax : mpc[i] + np;
            mfc[i] = mfc[i] + nf > smax ? smax : mfc[i] + nf;
        end
        for (int c = 0; c < NC; c++) begin
            r = int'(rq[i][c]);
            b = int'(bs[i][c]);
            g = int'(gn[i][c]);
            ep[i][c] = 0;
            ef[i][c] = 0;
            if (!en) begin
                trk[i][c] = 0;
                continue;
            end
            if (trk[i][c] == 0) begin
                if (r != 0) begin
                    trk[i][c] = 1; nb[i][c] = 0; age[i][c] = 0;
                end
                continue;
            end
            age[i][c]++;
            code = 0;
            ok = 0;
            if (g != 0) begin
                if (nb[i][c] == N) ok = 1;
                else code = 1;
            end else if (nb[i][c] == N && b != 0) code = 2;
            else if (nb[i][c] == N && mode == 1) code = 3;
            else if (age[i][c] == MW) code = 4;
            if (ok != 0 || code != 0) begin
                ep[i][c] = ok;
                ef[i][c] = code != 0 ? 1 : 0;
                if (code != 0) ec[i][c] = code;
                trk[i][c] = r; nb[i][c] = 0; age[i][c] = 0;
            end else if (r != 0) begin
                ef[i][c] = 1; ec[i][c] = 5;
                nb[i][c] = 0; age[i][c] = 0;
            end else if (b != 0) begin
                nb[i][c]++;
            end
        end
    endtask

    // stimulus biased by the model so that every outcome shows up regularly
    task automatic drive();
        int bp;
        en  = $urandom_range(99) < 97;
        clr = $urandom_range(99) < 3;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < NC; c++) begin
                bp = c == 3 ? 10 : 45;
                if (trk[i][c] == 0) begin
                    rq[i][c] = $urandom_range(99) < 25;
                    bs[i][c] = $urandom_range(99) < 20;
                    gn[i][c] = $urandom_range(99) < 10;
                end else if (nb[i][c] < N) begin
                    rq[i][c] = $urandom_range(99) < 3;
                    bs[i][c] = $urandom_range(99) < bp;
                    gn[i][c] = $urandom_range(99) < 4;
                end else begin
                    rq[i][c] = $urandom_range(99) < 3;
                    bs[i][c] = $urandom_range(99) < 8;
                    gn[i][c] = $urandom_range(99) < 70;
                end
            end
    endtask

    task automatic check_all(input string ph);
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NC; c++) begin
                chk($sformatf("%s d%0d ch%0d active", ph, i, c), 32'(act[i][c]), 32'(trk[i][c]));
                chk($sformatf("%s d%0d ch%0d pass", ph, i, c), 32'(ps[i][c]), 32'(ep[i][c]));
                chk($sformatf("%s d%0d ch%0d fail", ph, i, c), 32'(fl[i][c]), 32'(ef[i][c]));
                chk($sformatf("%s d%0d ch%0d fail_code", ph, i, c), 32'(fcd[i][3*c +: 3]), 32'(ec[i][c]));
            end
            chk($sformatf("%s d%0d pass_cnt", ph, i), i == 0 ? 32'(pc0) : 32'(pc1), 32'(mpc[i]));
            chk($sformatf("%s d%0d fail_cnt", ph, i), i == 0 ? 32'(fc0) : 32'(fc1), 32'(mfc[i]));
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rq[i] = '0; bs[i] = '0; gn[i] = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 600 == 300) begin
                #2 rst = 1'b1;
                #1 model_reset();
                check_all("async_rst");
                rst = 1'b0;
            end
            drive();
            step(0, 0, 65535);
            step(1, 1, 3);
            @(negedge clk);
            check_all("run");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/noncon_rep_checker.md
# noncon_rep_checker

Synthesizable multi-channel checker for request/busy/grant handshakes. After each `req`, it requires exactly `BUSY_COUNT` `busy` cycles, not necessarily consecutive, before `gnt`. Each channel runs in either non-consecutive mode (grant any time after the last busy) or goto mode (grant exactly one cycle after the last busy). It sits beside arbitrated DUT ports in simulation and FPGA builds, wherever SVA is unavailable. Outputs are per-channel pass/fail pulses with a failure code, plus saturating aggregate counters.

## Interface
- `NUM_CH`, 4: number of independent channels.
- `BUSY_COUNT`, 3: required busy occurrences N, ≥1.
- `MODE`, 0: 0 = non-consecutive (`[=N] ##1 gnt`); 1 = goto (`[->N] ##1 gnt`).
- `MAX_WAIT`, 64: cycles allowed in a transaction before timeout; 0 disables the timeout.
- `STAT_W`, 16: width of the aggregate counters.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset. All state and outputs clear immediately.
- `en` in 1: when low, channels hold in IDLE and `req` is ignored. An in-flight transaction is abandoned with no pulse.
- `clr_cnt` in 1: synchronous clear of `pass_cnt`/`fail_cnt`.
- `req` in NUM_CH: per-channel request, sampled each edge.
- `busy` in NUM_CH: per-channel busy.
- `gnt` in NUM_CH: per-channel grant.
- `active` out NUM_CH: channel is tracking a transaction. Reset 0.
- `pass` out NUM_CH: 1-cycle pulse when a transaction completes correctly. Reset 0.
- `fail` out NUM_CH: 1-cycle pulse when a transaction fails. Reset 0.
- `fail_code` out 3*NUM_CH: per-channel code, valid with `fail`, holds its last value otherwise. Reset 0.
- `pass_cnt` out STAT_W: saturating count of pass pulses across all channels. Reset 0.
- `fail_cnt` out STAT_W: saturating count of fail pulses across all channels. Reset 0.

## Operation
- Each channel has a 3-state FSM plus a busy counter `bc` (width clog2(N+1)) and a wait counter `wc` (width clog2(MAX_WAIT+1)).
- States:
  - IDLE: on `req`, go to COUNT with `bc`=0 and `wc`=0.
  - COUNT: `bc`<N.
  - DONE: `bc`==N, waiting for `gnt`.
- Evaluation on each edge in COUNT/DONE, using this cycle's inputs.
  - `gnt` is judged against `bc` before this cycle's `busy` is counted.
  - COUNT + `gnt` → fail code 1 (EARLY_GNT). Otherwise `busy` increments `bc`, and reaching N moves the FSM to DONE.
  - DONE + `gnt` → pass, go to IDLE. This applies even if `busy` is also high in that cycle.
  - DONE + `busy` + no `gnt` → fail code 2 (EXTRA_BUSY).
  - MODE=1 only: the first DONE cycle with no `gnt` → fail code 3 (MISSED_GNT).
  - `wc` increments on every cycle in COUNT/DONE. When `wc` reaches MAX_WAIT (MAX_WAIT>0) with no other decision → fail code 4 (TIMEOUT).
  - `req` in COUNT/DONE with no pass/fail decided in this cycle → fail code 5 (OVERLAP). The channel then restarts tracking from this `req`.
- When two failure conditions occur in the same cycle, the lower code wins.
- After a pass or any fail other than OVERLAP, the channel returns to IDLE. If `req` is high in that same cycle, it starts a new transaction directly in COUNT (back-to-back, no OVERLAP).
- Counters:
  - Each cycle, `pass_cnt` adds popcount(`pass` next) and `fail_cnt` adds popcount(`fail` next).
  - Both saturate at 2^STAT_W−1.
  - `clr_cnt` takes priority over increments in the same cycle.
- Channels are fully independent. No arbitration or shared state exists beyond the counters.

## Timing
- `req` sampled at edge k → `active`=1 after edge k. The first `busy`/`gnt` considered is the one sampled at edge k+1. A `busy` in the `req` cycle is not counted.
- A decision sampled at edge j → `pass`/`fail`/`fail_code` registered after edge j, high for exactly one cycle. `active` drops after the same edge unless a restart occurs.
- Minimum transaction length in MODE=1: `req`, then N busy cycles, then `gnt` → pass N+1 cycles after `req`.
- `pass_cnt`/`fail_cnt` are updated one edge after the corresponding pulse is visible.
- `rst` asserted mid-transaction clears the FSM, counters and outputs asynchronously. No pulse is emitted, and the channel is IDLE after release.

## Test plan
- N=3, MODE=0, ch0: `req`, then busy at +2, +4, +6, then `gnt` at +11 → `pass[0]` one cycle after the gnt edge; `pass_cnt`=1.
- N=3, MODE=1: same stimulus with `gnt` at +7 → pass. With `gnt` at +8 → `fail`, code 3, one cycle after +7.
- N=3, MODE=0: five busy pulses then `gnt` → fail code 2 at the 4th busy; the later `gnt` is ignored (IDLE).
- N=3: `gnt` after 2 busy → code 1. Separately, `req` again while in COUNT → code 5 with `active` held at 1 and restarted tracking. Separately, MAX_WAIT=10 with no busy → code 4 after 10 cycles.
- NUM_CH=4: ch0 passes and ch2 fails in the same cycle → `pass_cnt`+1 and `fail_cnt`+1. Pulse `clr_cnt` in the same cycle as pulses → both counters read 0.
- `rst` pulsed while ch1 is in DONE → all outputs 0 immediately. A new `req` after release passes normally. Also check `STAT_W`=2 saturates at 3.
